// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: two-port (capture write / display read) arbiter for a
// single memory command port. A request selected in IDLE owns the port
// until the memory controller reports completion or the burst times out.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W   = 30,
    parameter logic [5:0]  BURST_BL = 6'd31,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    // capture side
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    // display side
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    // ownership
    output logic              wr_grant,
    output logic              rd_grant,
    // memory controller command port
    output logic              mem_cmd_en,
    output logic [2:0]        mem_cmd_instr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [5:0]        mem_cmd_bl,
    input  logic              mem_cmd_full,
    input  logic              mem_done,
    // sticky burst-timeout flag
    output logic              err_timeout
);

    localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]  INSTR_WR = 3'b000;
    localparam logic [2:0]  INSTR_RD = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                wr_grant_q, wr_grant_d;
    logic                rd_grant_q, rd_grant_d;
    logic [2:0]          instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_rd_q, last_rd_d;

    logic                pick_rd;
    logic                pick_wr;
    logic                cnt_expire;

    // Requester selection: urgent read wins, otherwise the one not served last
    always_comb begin
        pick_rd = rd_req & (~wr_req | rd_urgent | ~last_rd_q);
        pick_wr = wr_req & ~pick_rd;
    end

    // Counter reaches TIMEOUT on this BUSY cycle (it holds cycles already spent)
    always_comb begin
        cnt_expire = (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_done in BUSY takes priority over expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pick_rd || pick_wr) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_cmd_full) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_done || cnt_expire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command strobe: one cycle in ISSUE once the queue can accept it
    always_comb begin
        mem_cmd_en = 1'b0;
        if ((state_q == S_ISSUE) && !mem_cmd_full) begin
            mem_cmd_en = 1'b1;
        end
    end

    // Grant, command latch, BUSY counter and round-robin history updates
    always_comb begin
        wr_grant_d = wr_grant_q;
        rd_grant_d = rd_grant_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        last_rd_d  = last_rd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_rd || pick_wr) begin
                    wr_grant_d = pick_wr;
                    rd_grant_d = pick_rd;
                    instr_d    = pick_rd ? INSTR_RD : INSTR_WR;
                    addr_d     = pick_rd ? rd_addr : wr_addr;
                end
            end
            S_ISSUE: begin
                if (!mem_cmd_full) begin
                    cnt_d = '0;
                end
            end
            S_BUSY: begin
                // Counter never passes TIMEOUT since BUSY is left when it gets there
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_done || cnt_expire) begin
                    wr_grant_d = 1'b0;
                    rd_grant_d = 1'b0;
                    // An aborted burst still counts as the owner's turn
                    last_rd_d  = rd_grant_q;
                    if (!mem_done) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            instr_q    <= 3'b000;
            addr_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            last_rd_q  <= 1'b1;
        end else begin
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            last_rd_q  <= last_rd_d;
        end
    end

    assign wr_grant      = wr_grant_q;
    assign rd_grant      = rd_grant_q;
    assign mem_cmd_instr = instr_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_bl    = BURST_BL;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboarded bench for fb_port_arbiter: the driver predicts each burst's
// owner from the arbitration rules and queues it; a monitor checks every
// command strobe against that queue.
module tb_fb_port_arbiter;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned TMO    = 16;

    logic              CLK;
    logic              RST;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_urgent;
    logic              wr_grant;
    logic              rd_grant;
    logic              mem_cmd_en;
    logic [2:0]        mem_cmd_instr;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [5:0]        mem_cmd_bl;
    logic              mem_cmd_full;
    logic              mem_done;
    logic              err_timeout;

    fb_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .BURST_BL(6'd31),
        .TIMEOUT (TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_urgent    (rd_urgent),
        .wr_grant     (wr_grant),
        .rd_grant     (rd_grant),
        .mem_cmd_en   (mem_cmd_en),
        .mem_cmd_instr(mem_cmd_instr),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_bl   (mem_cmd_bl),
        .mem_cmd_full (mem_cmd_full),
        .mem_done     (mem_done),
        .err_timeout  (err_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Expected command stream: {is_read, address}
    logic [ADDR_W:0] exp_q[$];

    // Reference state: who was served last and the sticky error
    bit m_last_rd = 1'b1;
    bit m_err     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every command strobe must match the next predicted burst
    logic [ADDR_W:0] mon_e;
    always @(negedge CLK) begin
        if (!RST) begin
            chk("grant_exclusive", 64'(wr_grant & rd_grant), 64'(0));
            if (mem_cmd_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd_en", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cmd_instr", 64'(mem_cmd_instr), mon_e[ADDR_W] ? 64'(1) : 64'(0));
                    chk("cmd_addr", 64'(mem_cmd_addr), 64'(mon_e[ADDR_W-1:0]));
                    chk("cmd_bl", 64'(mem_cmd_bl), 64'(31));
                    chk("cmd_grant", 64'({wr_grant, rd_grant}),
                        mon_e[ADDR_W] ? 64'(2'b01) : 64'(2'b10));
                end
            end
        end
    end

    // One burst starting in an IDLE cycle; done_at=0 means never complete (timeout)
    task automatic do_burst(input bit wr, input bit rd, input bit urg,
                            input int full_cyc, input int done_at,
                            input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra);
        bit              win_rd;
        logic [ADDR_W-1:0] ea;
        logic [1:0]      exp_g;
        int              limit;
        win_rd = rd && (!wr || urg || !m_last_rd);
        ea     = win_rd ? ra : wa;
        exp_g  = win_rd ? 2'b01 : 2'b10;
        exp_q.push_back({win_rd, ea});
        wr_req = wr; rd_req = rd; wr_addr = wa; rd_addr = ra;
        rd_urgent = urg; mem_cmd_full = (full_cyc > 0); mem_done = 1'b0;
        @(posedge CLK); #1;
        // Requests may drop and addresses move once the burst is selected
        if ($urandom_range(0, 1) == 0) begin
            wr_req = 1'b0; rd_req = 1'b0;
        end
        wr_addr = ADDR_W'($urandom); rd_addr = ADDR_W'($urandom);
        for (int i = 0; i < full_cyc; i++) begin
            mem_done = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("full_no_en", 64'(mem_cmd_en), 64'(0));
            chk("full_grant", 64'({wr_grant, rd_grant}), 64'(exp_g));
            chk("full_addr", 64'(mem_cmd_addr), 64'(ea));
            @(posedge CLK); #1;
        end
        mem_cmd_full = 1'b0;
        mem_done = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("issue_en", 64'(mem_cmd_en), 64'(1));
        chk("issue_grant", 64'({wr_grant, rd_grant}), 64'(exp_g));
        @(posedge CLK); #1;
        mem_done = 1'b0;
        limit = (done_at == 0) ? int'(TMO) : done_at;
        for (int k = 1; k <= limit; k++) begin
            if (k == done_at) mem_done = 1'b1;
            mem_cmd_full = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("busy_grant", 64'({wr_grant, rd_grant}), 64'(exp_g));
            chk("busy_no_en", 64'(mem_cmd_en), 64'(0));
            chk("busy_addr", 64'(mem_cmd_addr), 64'(ea));
            chk("busy_instr", 64'(mem_cmd_instr), win_rd ? 64'(1) : 64'(0));
            @(posedge CLK); #1;
            mem_done = 1'b0;
        end
        mem_cmd_full = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0;
        if (done_at == 0) m_err = 1'b1;
        m_last_rd = win_rd;
        @(negedge CLK);
        chk("idle_grants", 64'({wr_grant, rd_grant}), 64'(0));
        chk("idle_err", 64'(err_timeout), 64'(m_err));
        chk("idle_no_en", 64'(mem_cmd_en), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_grant"}, 64'(wr_grant), 64'(0));
        chk({tag, "_rd_grant"}, 64'(rd_grant), 64'(0));
        chk({tag, "_cmd_en"}, 64'(mem_cmd_en), 64'(0));
        chk({tag, "_instr"}, 64'(mem_cmd_instr), 64'(0));
        chk({tag, "_addr"}, 64'(mem_cmd_addr), 64'(0));
        chk({tag, "_err"}, 64'(err_timeout), 64'(0));
    endtask

    initial begin
        int r;
        RST = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0;
        wr_addr = '0; rd_addr = '0; mem_cmd_full = 1'b0; mem_done = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_outputs("reset");
        chk("reset_bl", 64'(mem_cmd_bl), 64'(31));
        RST = 1'b0;
        @(negedge CLK);

        // Single write at 0x100
        do_burst(1'b1, 1'b0, 1'b0, 0, 2, ADDR_W'(32'h100), ADDR_W'($urandom));

        // Both requesting, not urgent: alternate owners
        for (int i = 0; i < 4; i++) begin
            do_burst(1'b1, 1'b1, 1'b0, $urandom_range(0, 1), $urandom_range(1, 3),
                     ADDR_W'($urandom), ADDR_W'($urandom));
        end

        // Urgent read after a read burst: read again
        do_burst(1'b0, 1'b1, 1'b0, 0, 1, ADDR_W'($urandom), ADDR_W'($urandom));
        do_burst(1'b1, 1'b1, 1'b1, 0, 2, ADDR_W'($urandom), ADDR_W'($urandom));

        // Command queue full for 5 cycles
        do_burst(1'b1, 1'b0, 1'b0, 5, 2, ADDR_W'($urandom), ADDR_W'($urandom));

        // Completion exactly on the TIMEOUT cycle is normal
        do_burst(1'b1, 1'b0, 1'b0, 0, int'(TMO), ADDR_W'($urandom), ADDR_W'($urandom));

        // No completion: timeout, then a normal burst
        do_burst(1'b0, 1'b1, 1'b0, 0, 0, ADDR_W'($urandom), ADDR_W'($urandom));
        do_burst(1'b1, 1'b1, 1'b0, 0, 3, ADDR_W'($urandom), ADDR_W'($urandom));

        // Stray mem_done in IDLE does nothing
        mem_done = 1'b1;
        @(posedge CLK); #1;
        mem_done = 1'b0;
        @(negedge CLK);
        chk("idle_done_grants", 64'({wr_grant, rd_grant}), 64'(0));
        chk("idle_done_en", 64'(mem_cmd_en), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            do_burst(r[0], r[1], 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(1, 5), ADDR_W'($urandom), ADDR_W'($urandom));
        end

        // Reset during BUSY (err_timeout is set here, reset must clear it)
        wr_req = 1'b1; wr_addr = ADDR_W'($urandom);
        exp_q.push_back({1'b0, wr_addr});
        @(posedge CLK); #1;
        wr_req = 1'b0;
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        m_last_rd = 1'b1;
        m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("post_reset_no_en", 64'(mem_cmd_en), 64'(0));
            chk("post_reset_grants", 64'({wr_grant, rd_grant}), 64'(0));
        end

        // First contested grant after reset goes to write
        do_burst(1'b1, 1'b1, 1'b0, 0, 2, ADDR_W'($urandom), ADDR_W'($urandom));

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
